// File: rtl/timer_pkg.sv
// Shared constants, helpers and control-FSM state encodings for the countdown timer.
package timer_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX    = 4'd9;
  localparam int TICK_DIV_DEFAULT = 50_000_000;

  // State encodings used by the control FSM that drives load/run.
  // state     | meaning
  // INPUT     | operator edits preset, datapath held in load
  // COUNTDOWN | run asserted until done is seen
  // FINISH    | count expired, waiting for operator
  typedef enum logic [1:0] {
    INPUT     = 2'd0,
    COUNTDOWN = 2'd1,
    FINISH    = 2'd2
  } timer_state_t;

  // Saturate a BCD digit to its legal maximum.
  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d,
                                                     input logic [DIGIT_W-1:0] max);
    return (d > max) ? max : d;
  endfunction

endpackage

// File: rtl/timer_countdown_if.sv
// Control/display bundle between the timer FSM (master) and the countdown datapath (slave).
interface timer_countdown_if;
  import timer_pkg::*;

  logic               load;
  logic               run;
  logic [DIGIT_W-1:0] set_min_tens;
  logic [DIGIT_W-1:0] set_min_ones;
  logic [DIGIT_W-1:0] set_sec_tens;
  logic [DIGIT_W-1:0] set_sec_ones;
  logic [DIGIT_W-1:0] min_tens;
  logic [DIGIT_W-1:0] min_ones;
  logic [DIGIT_W-1:0] sec_tens;
  logic [DIGIT_W-1:0] sec_ones;
  logic               tick;
  logic               done;

  modport master (
    output load, run, set_min_tens, set_min_ones, set_sec_tens, set_sec_ones,
    input  min_tens, min_ones, sec_tens, sec_ones, tick, done
  );

  modport slave (
    input  load, run, set_min_tens, set_min_ones, set_sec_tens, set_sec_ones,
    output min_tens, min_ones, sec_tens, sec_ones, tick, done
  );

endinterface

// File: rtl/tick_gen.sv
// One-second prescaler: counts enabled cycles 0..TICK_DIV-1 and flags the terminal count.
module tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Tick is only meaningful on cycles that actually advance the prescaler.
  assign tick = en && !clr && !reset && (cnt == LAST);

  // Prescaler register; a clear restarts the second, a pause keeps the partial second.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/timer_countdown.sv
// MM:SS BCD countdown datapath: preset load with clamping, borrow-chained decrement, sticky done.
module timer_countdown
  import timer_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input logic         clk,
  input logic         reset,
  timer_countdown_if.slave bus
);

  logic [DIGIT_W-1:0] min_tens, min_ones, sec_tens, sec_ones;
  logic [DIGIT_W-1:0] nx_min_tens, nx_min_ones, nx_sec_tens, nx_sec_ones;
  logic               done;
  logic               tick;
  logic               is_zero;
  logic               dec_zero;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.load),
    .en    (bus.run),
    .tick  (tick)
  );

  assign is_zero  = (min_tens == '0) && (min_ones == '0) && (sec_tens == '0) && (sec_ones == '0);
  assign dec_zero = (nx_min_tens == '0) && (nx_min_ones == '0) &&
                    (nx_sec_tens == '0) && (nx_sec_ones == '0);

  // One-second decrement with borrow rippling from seconds up to minute tens.
  always_comb begin
    nx_sec_ones = sec_ones - 1'b1;
    nx_sec_tens = sec_tens;
    nx_min_ones = min_ones;
    nx_min_tens = min_tens;
    if (sec_ones == '0) begin
      nx_sec_ones = DIGIT_MAX;
      if (sec_tens == '0) begin
        nx_sec_tens = SEC_TENS_MAX;
        if (min_ones == '0) begin
          nx_min_ones = DIGIT_MAX;
          nx_min_tens = min_tens - 1'b1;
        end else begin
          nx_min_ones = min_ones - 1'b1;
        end
      end else begin
        nx_sec_tens = sec_tens - 1'b1;
      end
    end
  end

  // Digit registers and done flag; the count saturates at 00:00 so a late run cycle is harmless.
  always_ff @(posedge clk) begin
    if (reset) begin
      min_tens <= '0;
      min_ones <= '0;
      sec_tens <= '0;
      sec_ones <= '0;
      done     <= 1'b0;
    end else if (bus.load) begin
      min_tens <= clamp_digit(bus.set_min_tens, DIGIT_MAX);
      min_ones <= clamp_digit(bus.set_min_ones, DIGIT_MAX);
      sec_tens <= clamp_digit(bus.set_sec_tens, SEC_TENS_MAX);
      sec_ones <= clamp_digit(bus.set_sec_ones, DIGIT_MAX);
      done     <= 1'b0;
    end else if (bus.run) begin
      if (is_zero) begin
        done <= 1'b1;
      end else if (tick) begin
        min_tens <= nx_min_tens;
        min_ones <= nx_min_ones;
        sec_tens <= nx_sec_tens;
        sec_ones <= nx_sec_ones;
        if (dec_zero) begin
          done <= 1'b1;
        end
      end
    end
  end

  assign bus.min_tens = min_tens;
  assign bus.min_ones = min_ones;
  assign bus.sec_tens = sec_tens;
  assign bus.sec_ones = sec_ones;
  assign bus.tick     = tick;
  assign bus.done     = done;

endmodule

// File: tb/tb_timer_countdown.sv
// Self-checking bench for timer_countdown: directed scenarios plus random load/run/reset traffic,
// checked every cycle against a seconds-based reference model.
module tb_timer_countdown;

  localparam int TD = 4;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errs   = 0;

  // Reference model state: total seconds remaining and prescaler phase.
  int   m_total = 0;
  int   m_phase = 0;
  bit   m_done  = 0;

  timer_countdown_if bus_if ();

  timer_countdown #(.TICK_DIV(TD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic int lim(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  function automatic logic [15:0] model_digits();
    logic [15:0] d;
    d[15:12] = 4'(m_total / 600);
    d[11:8]  = 4'((m_total / 60) % 10);
    d[7:4]   = 4'((m_total % 60) / 10);
    d[3:0]   = 4'(m_total % 10);
    return d;
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_total = 0; m_phase = 0; m_done = 0;
    end else if (bus_if.load) begin
      m_total = (lim(int'(bus_if.set_min_tens), 9) * 10 + lim(int'(bus_if.set_min_ones), 9)) * 60
              + lim(int'(bus_if.set_sec_tens), 5) * 10 + lim(int'(bus_if.set_sec_ones), 9);
      m_phase = 0; m_done = 0;
    end else if (bus_if.run) begin
      if (m_total == 0) m_done = 1;
      if (m_phase == TD - 1) begin
        m_phase = 0;
        if (m_total > 0) begin
          m_total--;
          if (m_total == 0) m_done = 1;
        end
      end else begin
        m_phase++;
      end
    end
  endtask

  task automatic step();
    logic exp_tick;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    exp_tick = bus_if.run && !bus_if.load && !reset && (m_phase == TD - 1);
    check("digits", {16'h0, bus_if.min_tens, bus_if.min_ones, bus_if.sec_tens, bus_if.sec_ones},
          {16'h0, model_digits()});
    check("done", {31'h0, bus_if.done}, {31'h0, m_done});
    check("tick", {31'h0, bus_if.tick}, {31'h0, exp_tick});
  endtask

  task automatic cyc(input bit rst, input bit l, input bit r, input int n);
    reset = rst; bus_if.load = l; bus_if.run = r;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic preset(input int mt, input int mo, input int st, input int so);
    bus_if.set_min_tens = 4'(mt);
    bus_if.set_min_ones = 4'(mo);
    bus_if.set_sec_tens = 4'(st);
    bus_if.set_sec_ones = 4'(so);
  endtask

  function automatic logic [31:0] digits_now();
    return {16'h0, bus_if.min_tens, bus_if.min_ones, bus_if.sec_tens, bus_if.sec_ones};
  endfunction

  initial begin
    reset = 1'b1;
    bus_if.load = 1'b0;
    bus_if.run  = 1'b0;
    preset(0, 0, 0, 0);

    // Reset state
    cyc(1, 0, 0, 2);
    check("rst_digits", digits_now(), 32'h0);
    check("rst_done", {31'h0, bus_if.done}, 32'h0);
    check("rst_tick", {31'h0, bus_if.tick}, 32'h0);

    // 01:00 down to 00:00
    preset(0, 1, 0, 0);
    cyc(0, 1, 0, 1);
    check("load_0100", digits_now(), 32'h0100);
    cyc(0, 0, 1, 4);
    check("first_dec", digits_now(), 32'h0059);
    cyc(0, 0, 1, 235);
    check("before_zero_done", {31'h0, bus_if.done}, 32'h0);
    cyc(0, 0, 1, 1);
    check("zero_digits", digits_now(), 32'h0);
    check("zero_done", {31'h0, bus_if.done}, 32'h1);

    // Full borrow chain
    preset(1, 0, 0, 0);
    cyc(0, 1, 0, 1);
    check("done_cleared_by_load", {31'h0, bus_if.done}, 32'h0);
    cyc(0, 0, 1, 4);
    check("borrow_chain", digits_now(), 32'h0959);

    // Pause keeps partial second
    preset(0, 0, 0, 2);
    cyc(0, 1, 0, 1);
    cyc(0, 0, 1, 6);
    cyc(0, 0, 0, 10);
    check("pause_digits", digits_now(), 32'h0001);
    check("pause_done", {31'h0, bus_if.done}, 32'h0);
    cyc(0, 0, 1, 1);
    check("resume_one", digits_now(), 32'h0001);
    cyc(0, 0, 1, 1);
    check("resume_zero", digits_now(), 32'h0);
    check("resume_done", {31'h0, bus_if.done}, 32'h1);

    // Already zero
    preset(0, 0, 0, 0);
    cyc(0, 1, 0, 1);
    cyc(0, 0, 1, 1);
    check("zero_run_done", {31'h0, bus_if.done}, 32'h1);
    cyc(0, 0, 1, 9);
    check("zero_hold", digits_now(), 32'h0);

    // Clamp and load+run priority
    preset(9, 9, 7, 12);
    cyc(0, 1, 0, 1);
    check("clamp", digits_now(), 32'h9959);
    cyc(0, 1, 1, 8);
    check("load_run_hold", digits_now(), 32'h9959);
    cyc(0, 0, 1, 3);
    check("no_phase_yet", digits_now(), 32'h9959);
    cyc(0, 0, 1, 1);
    check("after_load_run", digits_now(), 32'h9958);

    // Reset mid-count
    preset(0, 0, 3, 0);
    cyc(0, 1, 0, 1);
    cyc(0, 0, 1, 2);
    cyc(1, 0, 1, 1);
    check("midrst_digits", digits_now(), 32'h0);
    check("midrst_done", {31'h0, bus_if.done}, 32'h0);
    check("midrst_tick", {31'h0, bus_if.tick}, 32'h0);
    cyc(0, 0, 1, 1);
    check("post_rst_done", {31'h0, bus_if.done}, 32'h1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bit r_rst, r_load, r_run;
      r_rst  = ($urandom_range(0, 99) == 0);
      r_load = ($urandom_range(0, 39) == 0);
      r_run  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 0)
        preset(0, 0, $urandom_range(0, 1), $urandom_range(0, 15));
      else
        preset($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
               $urandom_range(0, 15));
      cyc(r_rst, r_load, r_run, 1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
